instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream stage of the didactic processor. Holds a program counter and reads 9-bit instruction words from a synchronous program memory. It presents each word on the processor's DataAndInstructionInput with a one-cycle Run pulse, then waits for the processor's Done. For a movi instruction it fetches the following immediate word and places it on the same bus before waiting. It stops on a reserved halt opcode.

Parameters:
dataWidth, 9, width of instruction/data word (fields: [2:0] opcode, [5:3] regX, [8:6] regY)
addrWidth, 5, program memory address width; PC wraps modulo 2^addrWidth
countWidth, 16, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; while high the unit fetches and issues continuously
memAddress  output  addrWidth  program memory read address
memReadEn  output  1  memory read strobe; data valid the cycle after
memReadData  input  dataWidth  memory read data (1-cycle latency)
Done  input  1  processor completion pulse
DataAndInstructionInput  output  dataWidth  word driven to processor
Run  output  1  one-cycle issue pulse to processor
pc  output  addrWidth  current program counter
retiredCount  output  countWidth  number of instructions completed (Done received)
halted  output  1  high while in HALTED state

Behaviour:
- Reset (async, any state): state=IDLE; pc=0, DataAndInstructionInput=0, Run=0, memReadEn=0, memAddress=0, retiredCount=0, halted=0, doneSeen=0. All outputs are zero while reset is high.
- FSM states:
  - IDLE: start=1 -> FETCH.
  - FETCH: memAddress=pc, memReadEn=1 -> LATCH.
  - LATCH: instrReg<=memReadData; pc<=pc+1. Opcode==HALT -> HALTED, else -> ISSUE.
  - ISSUE: DataAndInstructionInput=instrReg, Run=1 for exactly this cycle; doneSeen<=0. Opcode==MOVI -> IMM_FETCH, else -> WAIT_DONE.
  - IMM_FETCH: memAddress=pc, memReadEn=1 -> IMM_LATCH.
  - IMM_LATCH: DataAndInstructionInput<=memReadData; pc<=pc+1 -> WAIT_DONE.
  - WAIT_DONE: on (Done | doneSeen): retiredCount+1; start=1 -> FETCH, start=0 -> IDLE.
  - HALTED: halted=1. Leaves only on reset. pc stays at halt address+1.
- Latency: start sampled high in IDLE at edge k puts Run high in the cycle after edge k+3. Back-to-back non-immediate instructions issue every 4 cycles + Done wait.
- DataAndInstructionInput holds its last value outside ISSUE/IMM_LATCH updates. It is never X after reset.
- Done asserted in any cycle after ISSUE (including IMM_FETCH/IMM_LATCH) sets doneSeen, so an early Done is not lost. Done in IDLE, FETCH, LATCH, ISSUE, HALTED is ignored.
- Done and reset coincident: reset wins, count stays 0.
- PC arithmetic is modulo 2^addrWidth: pc=2^addrWidth-1 increments to 0 silently, including when an immediate sits at the last address.
- retiredCount saturates at all-ones (no wrap).
- start dropping mid-instruction: the current instruction completes. Return to IDLE only from WAIT_DONE.
- Opcodes other than MOVI/HALT (mov, add, sub, unused 4-6) are issued as single words.

Decomposition:
- Shared package processor_pkg: opcode enum (MOV=0, MOVI=1, ADD=2, SUB=3, HALT=7), field-slice constants (OPCODE_LSB=0, REGX_LSB=3, REGY_LSB=6, FIELD_W=3), fetch state enum.
- Package also holds a helper function hasImmediate(opcode).
- One sub-module: program_counter (loadable, increment, modulo wrap). FSM and counter stay in the top.

Test Plan:
- Reset mid-IMM_FETCH with pc=3 -> all outputs 0 immediately (async), state IDLE, Run never pulses.
- mem[0]=0x008 (mov R1,R0); start=1; Done pulsed 2 cycles after Run -> Run high 1 cycle with bus=0x008, memAddress=0 seen once, retiredCount=1, next fetch at pc=1.
- mem[1]=0x011 (movi R2), mem[2]=0x05A -> Run with bus=0x011, then bus=0x05A two cycles later, pc=3 after, retiredCount increments on Done.
- Done asserted during IMM_LATCH -> doneSeen captures it; WAIT_DONE exits next cycle, count+1 exactly once.
- mem[3]=0x007 (halt) -> halted=1, Run stays 0, pc=4; further Done pulses leave retiredCount unchanged.
- addrWidth=2, mem[3]=0x001 (movi), mem[0]=0x0AA immediate -> immediate fetched from address 0, pc wraps to 1.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the didactic processor: instruction field layout,
// opcodes and the fetch unit's state encoding.
package processor_pkg;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned REGX_LSB   = 3;
  localparam int unsigned REGY_LSB   = 6;
  localparam int unsigned FIELD_W    = 3;

  typedef enum logic [FIELD_W-1:0] {
    MOV  = 3'd0,
    MOVI = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    HALT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    FS_IDLE      = 3'd0,
    FS_FETCH     = 3'd1,
    FS_LATCH     = 3'd2,
    FS_ISSUE     = 3'd3,
    FS_IMM_FETCH = 3'd4,
    FS_IMM_LATCH = 3'd5,
    FS_WAIT_DONE = 3'd6,
    FS_HALTED    = 3'd7
  } fetchState_e;

  // movi is the only instruction followed by a data word in program memory.
  function automatic logic hasImmediate(logic [FIELD_W-1:0] opcode);
    return opcode == MOVI;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: optional parallel load, otherwise increments
// modulo 2^addrWidth.
module program_counter #(
  parameter int addrWidth = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [addrWidth-1:0] loadValue,
  input  logic                 increment,
  output logic [addrWidth-1:0] pc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= loadValue;
    end else if (increment) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the didactic processor: reads program words, issues them to
// the processor with a Run pulse and waits for Done before fetching again.
module instruction_fetch_unit
  import processor_pkg::*;
#(
  parameter int dataWidth  = 9,
  parameter int addrWidth  = 5,
  parameter int countWidth = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [addrWidth-1:0]  memAddress,
  output logic                  memReadEn,
  input  logic [dataWidth-1:0]  memReadData,
  input  logic                  Done,
  output logic [dataWidth-1:0]  DataAndInstructionInput,
  output logic                  Run,
  output logic [addrWidth-1:0]  pc,
  output logic [countWidth-1:0] retiredCount,
  output logic                  halted,
  output logic [2:0]            debugState
);

  localparam logic [2:0] IDLE      = FS_IDLE;
  localparam logic [2:0] FETCH     = FS_FETCH;
  localparam logic [2:0] LATCH     = FS_LATCH;
  localparam logic [2:0] ISSUE     = FS_ISSUE;
  localparam logic [2:0] IMM_FETCH = FS_IMM_FETCH;
  localparam logic [2:0] IMM_LATCH = FS_IMM_LATCH;
  localparam logic [2:0] WAIT_DONE = FS_WAIT_DONE;
  localparam logic [2:0] HALTED    = FS_HALTED;

  // Processor handshake: Run is a one-cycle issue pulse carrying the word on
  // DataAndInstructionInput (a movi's immediate follows two cycles later on
  // the same bus); Done is a one-cycle completion pulse that may arrive any
  // cycle after Run, and is remembered in doneSeen until WAIT_DONE consumes it.
  logic [2:0]           state;
  logic [2:0]           nextState;
  logic [dataWidth-1:0] instrReg;
  logic                 doneSeen;
  logic                 doneEvent;
  logic                 pcIncrement;
  logic [FIELD_W-1:0]   readOpcode;
  logic [FIELD_W-1:0]   issueOpcode;

  assign readOpcode  = memReadData[OPCODE_LSB +: FIELD_W];
  assign issueOpcode = instrReg[OPCODE_LSB +: FIELD_W];
  assign doneEvent   = Done | doneSeen;
  assign pcIncrement = (state == LATCH) || (state == IMM_LATCH);

  program_counter #(
    .addrWidth(addrWidth)
  ) u_programCounter (
    .clock    (clock),
    .reset    (reset),
    .load     (1'b0),
    .loadValue('0),
    .increment(pcIncrement),
    .pc       (pc)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (start) nextState = FETCH;
      FETCH:     nextState = LATCH;
      LATCH:     nextState = (readOpcode == HALT) ? HALTED : ISSUE;
      ISSUE:     nextState = hasImmediate(issueOpcode) ? IMM_FETCH : WAIT_DONE;
      IMM_FETCH: nextState = IMM_LATCH;
      IMM_LATCH: nextState = WAIT_DONE;
      WAIT_DONE: if (doneEvent) nextState = start ? FETCH : IDLE;
      HALTED:    nextState = HALTED;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                   <= IDLE;
      instrReg                <= '0;
      DataAndInstructionInput <= '0;
      Run                     <= 1'b0;
      retiredCount            <= '0;
      doneSeen                <= 1'b0;
    end else begin
      state <= nextState;
      Run   <= (state == ISSUE);
      case (state)
        LATCH: instrReg <= memReadData;
        ISSUE: begin
          DataAndInstructionInput <= instrReg;
          doneSeen                <= 1'b0;
        end
        IMM_FETCH: if (Done) doneSeen <= 1'b1;
        IMM_LATCH: begin
          DataAndInstructionInput <= memReadData;
          if (Done) doneSeen <= 1'b1;
        end
        // Count saturates so a long-running program never reports a wrapped total.
        WAIT_DONE: if (doneEvent && !(&retiredCount)) retiredCount <= retiredCount + 1'b1;
        default: ;
      endcase
    end
  end

  assign memReadEn  = (state == FETCH) || (state == IMM_FETCH);
  assign memAddress = memReadEn ? pc : '0;
  assign halted     = (state == HALTED);
  assign debugState = state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed and random programs checked
// against a program-walking reference model.
module tb_instruction_fetch_unit;
  import processor_pkg::*;

  localparam int DW  = 9;
  localparam int AW  = 5;
  localparam int CW  = 16;
  localparam int AW2 = 2;
  localparam int CW2 = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, startDrv, doneDrv, sel;
  logic startA, startB, doneA, doneB;
  assign startA = startDrv & ~sel;
  assign startB = startDrv & sel;
  assign doneA  = doneDrv & ~sel;
  assign doneB  = doneDrv & sel;

  logic [AW-1:0]  memAddressA, pcA;
  logic           memReadEnA, runA, haltedA;
  logic [DW-1:0]  memReadDataA = '0;
  logic [DW-1:0]  busA;
  logic [CW-1:0]  countA;
  logic [2:0]     stateA;

  logic [AW2-1:0] memAddressB, pcB;
  logic           memReadEnB, runB, haltedB;
  logic [DW-1:0]  memReadDataB = '0;
  logic [DW-1:0]  busB;
  logic [CW2-1:0] countB;
  logic [2:0]     stateB;

  logic [DW-1:0] memA [32];
  logic [DW-1:0] memB [4];

  always @(posedge clock) if (memReadEnA) memReadDataA <= memA[memAddressA];
  always @(posedge clock) if (memReadEnB) memReadDataB <= memB[memAddressB];

  instruction_fetch_unit #(.dataWidth(DW), .addrWidth(AW), .countWidth(CW)) dutA (
    .clock(clock), .reset(reset), .start(startA),
    .memAddress(memAddressA), .memReadEn(memReadEnA), .memReadData(memReadDataA),
    .Done(doneA), .DataAndInstructionInput(busA), .Run(runA), .pc(pcA),
    .retiredCount(countA), .halted(haltedA), .debugState(stateA)
  );

  instruction_fetch_unit #(.dataWidth(DW), .addrWidth(AW2), .countWidth(CW2)) dutB (
    .clock(clock), .reset(reset), .start(startB),
    .memAddress(memAddressB), .memReadEn(memReadEnB), .memReadData(memReadDataB),
    .Done(doneB), .DataAndInstructionInput(busB), .Run(runB), .pc(pcB),
    .retiredCount(countB), .halted(haltedB), .debugState(stateB)
  );

  // Observation of whichever DUT is currently selected.
  logic          obsRun, obsHalted, obsMemEn;
  logic [DW-1:0] obsBus;
  logic [AW-1:0] obsPc, obsMemAddr;
  logic [CW-1:0] obsCount;
  logic [2:0]    obsState;
  assign obsRun     = sel ? runB : runA;
  assign obsHalted  = sel ? haltedB : haltedA;
  assign obsMemEn   = sel ? memReadEnB : memReadEnA;
  assign obsBus     = sel ? busB : busA;
  assign obsPc      = sel ? {{(AW-AW2){1'b0}}, pcB} : pcA;
  assign obsMemAddr = sel ? {{(AW-AW2){1'b0}}, memAddressB} : memAddressA;
  assign obsCount   = sel ? {{(CW-CW2){1'b0}}, countB} : countA;
  assign obsState   = sel ? stateB : stateA;

  // ---------------- scoreboard / reference model ----------------
  int asserts = 0;
  int fails   = 0;
  int mPc, mCount, mask, cmax;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] memRead(input int a);
    return sel ? memB[2'(a)] : memA[5'(a)];
  endfunction

  function automatic int incPc(input int a);
    return (a + 1) & mask;
  endfunction

  task automatic modelReset(input bit useB);
    sel    = useB;
    mask   = useB ? 3 : 31;
    cmax   = useB ? 7 : 65535;
    mPc    = 0;
    mCount = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1; startDrv = 1'b0; doneDrv = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_pc"},    obsPc, 0);
    check({tag, "_run"},   obsRun, 0);
    check({tag, "_bus"},   obsBus, 0);
    check({tag, "_count"}, obsCount, 0);
    check({tag, "_halt"},  obsHalted, 0);
    check({tag, "_mem"},   {obsMemEn, obsMemAddr}, 0);
    check({tag, "_state"}, obsState, FS_IDLE);
  endtask

  task automatic waitRun(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clock);
      n++;
      if (obsRun) ok = 1'b1;
    end
  endtask

  // Expect the next instruction of the program to issue; Done is pulsed d
  // cycles after the Run cycle.
  task automatic issueNext(input int d, input int expLat, input bit dropStart);
    logic [DW-1:0] w, imm;
    bit mv, ok;
    int addr, e, n;
    addr = mPc;
    w    = memRead(mPc);
    mPc  = incPc(mPc);
    mv   = (w[2:0] == 3'd1);
    imm  = '0;
    if (mv) begin
      imm = memRead(mPc);
      mPc = incPc(mPc);
    end
    waitRun(n, ok);
    check("run_seen", ok, 1);
    if (!ok) return;
    if (expLat >= 0) check("issue_latency", n, expLat);
    check("issue_bus", obsBus, w);
    check("pc_at_run", obsPc, (addr + 1) & mask);
    if (dropStart) startDrv = 1'b0;
    e = mv ? ((d > 2) ? d : 2) : d;
    for (int c = 0; c <= e + 1; c++) begin
      if (c > 0) @(negedge clock);
      doneDrv = (c == d);
      if (c == 1) check("run_one_cycle", obsRun, 0);
      if (mv && c == 2) begin
        check("imm_bus", obsBus, imm);
        check("pc_after_imm", obsPc, mPc);
      end
      if (c == e) check("count_before_done", obsCount, mCount);
    end
    doneDrv = 1'b0;
    if (mCount < cmax) mCount++;
    check("retired", obsCount, mCount);
  endtask

  task automatic expectHalt();
    bit sawRun;
    sawRun = 1'b0;
    mPc = incPc(mPc);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (obsRun) sawRun = 1'b1;
      doneDrv = (c >= 4) && (c % 2 == 0);
    end
    doneDrv = 1'b0;
    check("halt_no_run", sawRun, 0);
    check("halted", obsHalted, 1);
    check("halt_pc", obsPc, mPc);
    check("halt_count", obsCount, mCount);
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    w = DW'($urandom_range(0, 511));
    if ($urandom_range(0, 2) == 0) w[2:0] = 3'd1;
    else if (w[2:0] == 3'd7) w[2:0] = 3'($urandom_range(0, 6));
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int n;
    reset = 1'b1; startDrv = 1'b0; doneDrv = 1'b0;
    modelReset(0);
    memA[0] = 9'h008; memA[1] = 9'h008; memA[2] = 9'h011; memA[3] = 9'h155;
    for (int i = 4; i < 32; i++) memA[i] = 9'h000;
    memB[0] = 9'h0AA; memB[1] = 9'h008; memB[2] = 9'h010; memB[3] = 9'h001;
    @(negedge clock);
    @(negedge clock);
    checkZero("reset_a");
    reset = 1'b0;

    // Asynchronous reset landing in IMM_FETCH at pc=3.
    startDrv = 1'b1;
    issueNext(2, 4, 0);
    issueNext(0, 3, 0);
    waitRun(n, ok);
    check("movi_run_seen", ok, 1);
    check("immfetch_state", obsState, FS_IMM_FETCH);
    check("immfetch_pc", obsPc, 3);
    check("immfetch_mem", {obsMemEn, obsMemAddr}, {1'b1, 5'd3});
    #2 reset = 1'b1;
    #1 checkZero("async_reset");
    startDrv = 1'b0;
    @(negedge clock);
    check("reset_hold_run", obsRun, 0);
    @(negedge clock);
    checkZero("reset_hold");
    reset = 1'b0;

    // Directed program: mov, movi with Done in IMM_LATCH, halt.
    memA[0] = 9'h008; memA[1] = 9'h011; memA[2] = 9'h05A; memA[3] = 9'h007;
    modelReset(0);
    startDrv = 1'b1;
    issueNext(2, 4, 0);
    issueNext(1, 3, 0);
    expectHalt();

    // Random program that wraps the address space.
    applyReset();
    modelReset(0);
    checkZero("reset_rand");
    for (int i = 0; i < 32; i++) memA[i] = randWord();
    startDrv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issueNext($urandom_range(0, 4), (i == 0 || i == 21) ? 4 : 3, (i == 20));
      if (i == 20) begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clock);
          check("idle_no_run", obsRun, 0);
        end
        check("idle_state", obsState, FS_IDLE);
        check("idle_pc", obsPc, mPc);
        startDrv = 1'b1;
      end
    end
    issueNext($urandom_range(0, 4), 3, 1);
    memA[5'(mPc)] = {6'($urandom_range(0, 63)), 3'd7};
    startDrv = 1'b1;
    expectHalt();

    // Narrow instance: immediate at the last address, count saturation.
    sel = 1'b1;
    applyReset();
    modelReset(1);
    checkZero("reset_b");
    startDrv = 1'b1;
    for (int i = 0; i < 12; i++) issueNext($urandom_range(0, 3), (i == 0) ? 4 : 3, (i == 11));
    check("b_not_halted", obsHalted, 0);
    check("b_final_pc", obsPc, mPc);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
